// File: rtl/uart_serial_tx.sv
// uart_serial_tx: parallel word to 8E1-style serial frame (start, LSB-first data,
// even parity, stop), each bit held CLKS_PER_BIT clocks on a registered line.
//
// Ports:
//   clk        - single clock, rising edge
//   reset      - asynchronous, active-high
//   iTransmit  - start request, sampled only while idle
//   iData      - word to send, captured on the accepting edge
//   oSerialOut - serial line, registered, idles high
//   oTxBusy    - high from the cycle after acceptance until frame completion
//   oTxDone    - one-cycle pulse after the stop bit
module uart_serial_tx #(
  parameter int WORD_LENGTH  = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   iTransmit,
  input  logic [WORD_LENGTH-1:0] iData,
  output logic                   oSerialOut,
  output logic                   oTxBusy,
  output logic                   oTxDone
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(WORD_LENGTH + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST =
    BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST =
    BIT_W'(WORD_LENGTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } txState_t;

  txState_t state;
  txState_t stateNext;

  logic [BAUD_W-1:0]      baudCnt;
  logic [BAUD_W-1:0]      baudCntNext;
  logic [BIT_W-1:0]       bitCnt;
  logic [BIT_W-1:0]       bitCntNext;
  logic [WORD_LENGTH-1:0] shiftReg;
  logic [WORD_LENGTH-1:0] shiftRegNext;
  logic [WORD_LENGTH-1:0] shifted;
  logic                   parityBit;
  logic                   parityBitNext;
  logic                   serialNext;
  logic                   busyNext;
  logic                   doneNext;
  logic                   bitEnd;

  // Last clock of the current bit period.
  assign bitEnd  = (baudCnt == BAUD_LAST);
  assign shifted = shiftReg >> 1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      baudCnt    <= '0;
      bitCnt     <= '0;
      shiftReg   <= '0;
      parityBit  <= 1'b0;
      oSerialOut <= 1'b1;
      oTxBusy    <= 1'b0;
      oTxDone    <= 1'b0;
    end else begin
      state      <= stateNext;
      baudCnt    <= baudCntNext;
      bitCnt     <= bitCntNext;
      shiftReg   <= shiftRegNext;
      parityBit  <= parityBitNext;
      oSerialOut <= serialNext;
      oTxBusy    <= busyNext;
      oTxDone    <= doneNext;
    end
  end

  // The line value is computed one edge ahead so that each bit appears on
  // the registered output exactly on its bit-boundary edge.
  always_comb begin
    stateNext     = state;
    baudCntNext   = baudCnt;
    bitCntNext    = bitCnt;
    shiftRegNext  = shiftReg;
    parityBitNext = parityBit;
    serialNext    = oSerialOut;
    busyNext      = 1'b1;
    doneNext      = 1'b0;

    if (state != IDLE) begin
      baudCntNext = bitEnd ? '0 : baudCnt + 1'b1;
    end

    unique case (state)
      IDLE: begin
        serialNext = 1'b1;
        busyNext   = 1'b0;
        if (iTransmit) begin
          stateNext     = START;
          shiftRegNext  = iData;
          parityBitNext = ^iData;
          baudCntNext   = '0;
          bitCntNext    = '0;
          serialNext    = 1'b0;
          busyNext      = 1'b1;
        end
      end
      START: begin
        if (bitEnd) begin
          stateNext  = DATA;
          serialNext = shiftReg[0];
        end
      end
      DATA: begin
        if (bitEnd) begin
          if (bitCnt == BIT_LAST) begin
            stateNext  = PARITY;
            serialNext = parityBit;
          end else begin
            shiftRegNext = shifted;
            bitCntNext   = bitCnt + 1'b1;
            serialNext   = shifted[0];
          end
        end
      end
      PARITY: begin
        if (bitEnd) begin
          stateNext  = STOP;
          serialNext = 1'b1;
        end
      end
      STOP: begin
        if (bitEnd) begin
          stateNext  = IDLE;
          serialNext = 1'b1;
          busyNext   = 1'b0;
          doneNext   = 1'b1;
        end
      end
      default: begin
        stateNext  = IDLE;
        serialNext = 1'b1;
        busyNext   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_serial_tx.sv
// tb_uart_serial_tx: directed frames with hand-computed parity; a monitor
// pops expected frames and checks every line cycle, busy and done timing.
module tb_uart_serial_tx;

  localparam int CPB = 4;

  typedef struct {
    logic [10:0] bits;
    bit          b2b;
  } expT;

  logic       clk;
  logic       reset;
  logic       iTransmit;
  logic [7:0] iData;
  logic       oSerialOut;
  logic       oTxBusy;
  logic       oTxDone;

  expT expQ[$];
  int  compared   = 0;
  int  mismatched = 0;
  int  frameNo    = 0;
  bit  monActive  = 0;

  uart_serial_tx #(
    .WORD_LENGTH (8),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .iTransmit (iTransmit),
    .iData     (iData),
    .oSerialOut(oSerialOut),
    .oTxBusy   (oTxBusy),
    .oTxDone   (oTxDone)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic expT mkExp(input logic [7:0] d,
                                input logic p,
                                input bit b2b);
    expT e;
    e.bits = {1'b1, p, d, 1'b0};
    e.b2b  = b2b;
    return e;
  endfunction

  // One-cycle request; returns at the first negedge after acceptance.
  task automatic send(input logic [7:0] d, input logic p);
    @(negedge clk);
    iData     = d;
    iTransmit = 1'b1;
    expQ.push_back(mkExp(d, p, 1'b0));
    @(negedge clk);
    iTransmit = 1'b0;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while ((expQ.size() != 0 || monActive) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      compared++;
      mismatched++;
      $display("FAIL drainTimeout: %0d frames left after %0d cycles",
               expQ.size(), n);
    end
  endtask

  initial begin : monitor
    expT  cur;
    bit   go;
    bit   aborted;
    bit   busyOk;
    logic badLine;
    logic lastLine;
    logic [7:0] rxData;
    logic rxPar;
    int   n;
    go = 0;
    forever begin
      if (!go) begin
        @(negedge clk);
        if (reset === 1'b1) continue;
        if (oTxDone !== 1'b0) check("spuriousDone", oTxDone, 0);
        if (oSerialOut !== 1'b0) continue;
      end
      go = 0;
      if (expQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpectedFrame: line low at %0t, none expected",
                 $time);
        n = 0;
        while (oTxBusy === 1'b1 && n < 1000) begin
          @(negedge clk);
          n++;
        end
        continue;
      end
      cur = expQ.pop_front();
      monActive = 1;
      frameNo++;
      aborted = 0;
      rxData = '0;
      rxPar = 1'b0;
      lastLine = 1'b0;
      for (int k = 0; k < 11; k++) begin
        busyOk  = 1;
        badLine = cur.bits[k];
        for (int c = 0; c < CPB; c++) begin
          if (k != 0 || c != 0) @(negedge clk);
          if (reset === 1'b1) begin
            aborted = 1;
            break;
          end
          if (oSerialOut !== cur.bits[k]) badLine = oSerialOut;
          if (oTxBusy !== 1'b1 || oTxDone !== 1'b0) busyOk = 0;
          lastLine = oSerialOut;
        end
        if (aborted) break;
        check($sformatf("f%0d_bit%0d", frameNo, k),
              badLine, cur.bits[k]);
        check($sformatf("f%0d_busy%0d", frameNo, k), busyOk, 1);
        if (k >= 1 && k <= 8) rxData[k-1] = lastLine;
        if (k == 9) rxPar = lastLine;
      end
      if (aborted) begin
        monActive = 0;
        continue;
      end
      check($sformatf("f%0d_rxData", frameNo), rxData, cur.bits[8:1]);
      check($sformatf("f%0d_rxParErr", frameNo), ^{rxData, rxPar}, 0);
      @(negedge clk);
      if (reset === 1'b1) begin
        monActive = 0;
        continue;
      end
      check($sformatf("f%0d_doneCycle", frameNo),
            {oTxDone, oTxBusy, oSerialOut}, 3'b101);
      monActive = 0;
      if (expQ.size() > 0 && expQ[0].b2b) begin
        @(negedge clk);
        check("b2bGap", {oSerialOut, oTxDone}, 2'b00);
        go = (oSerialOut === 1'b0);
      end
    end
  end

  initial begin : stimulus
    bit sawActivity;
    reset     = 1'b0;
    iTransmit = 1'b0;
    iData     = 8'h00;

    // Asserted between edges: outputs must follow without a clock.
    #2 reset = 1'b1;
    #1;
    check("rstLine", oSerialOut, 1);
    check("rstBusy", oTxBusy, 0);
    check("rstDone", oTxDone, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    sawActivity = 0;
    repeat (100) begin
      @(negedge clk);
      if (oSerialOut !== 1'b1 || oTxBusy !== 1'b0) sawActivity = 1;
    end
    check("idleQuiet", sawActivity, 0);

    send(8'hA5, 1'b0);
    waitDrain();
    send(8'h07, 1'b1);
    waitDrain();
    send(8'h80, 1'b1);
    waitDrain();

    // Back to back: word changes mid-frame, request held throughout.
    @(negedge clk);
    iData     = 8'h00;
    iTransmit = 1'b1;
    expQ.push_back(mkExp(8'h00, 1'b0, 1'b0));
    expQ.push_back(mkExp(8'hFF, 1'b0, 1'b1));
    repeat (20) @(negedge clk);
    iData = 8'hFF;
    repeat (40) @(negedge clk);
    iTransmit = 1'b0;
    waitDrain();

    // Request during an active frame must be dropped.
    send(8'h81, 1'b0);
    repeat (9) @(negedge clk);
    iData     = 8'h3C;
    iTransmit = 1'b1;
    @(negedge clk);
    iTransmit = 1'b0;
    waitDrain();
    repeat (60) @(negedge clk);
    check("noQueuedFrame", expQ.size(), 0);

    // Reset during data bit 3 abandons the frame.
    send(8'h96, 1'b0);
    repeat (17) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midRstLine", oSerialOut, 1);
    check("midRstBusy", oTxBusy, 0);
    check("midRstDone", oTxDone, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    send(8'h5A, 1'b0);
    waitDrain();
    repeat (20) @(negedge clk);
    check("queueEmpty", expQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
